// File: rtl/gpio_owner_switch_ctrl.sv
// gpio_owner_switch_ctrl
//   Reassigns the owner of one GPIO pin at a time using a break-before-make
//   sequence. The pin is forced tristate (BREAK), held there for GUARD_CYCLES
//   cycles (GUARD), gets its new owner select while still tristate (MAKE),
//   and is then released (IDLE).
//
//   Optional feature: define GPIO_OWNER_LOCK_EN to build sticky per-pin
//   locks. A request with lock_set_i = 1 locks the pin, and every later
//   request to a locked pin is rejected. Locks clear only on reset.
//
//   Ports
//     wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//     req_valid_i/ready_o  request handshake (ready only in IDLE)
//     req_pin_i            target pin index
//     req_team_i           new owner index
//     lock_set_i           lock request (GPIO_OWNER_LOCK_EN only)
//     busy_o               sequence in progress
//     done_o               completion pulse (MAKE cycle or no-op request)
//     err_o                rejection pulse
//     pin_sel_o            per-pin owner select, pin p at [4p+3:4p]
//     force_oeb_o          per-pin tristate override

// Per-pin owner select register plus optional sticky lock bit.
module gpio_owner_pin_cell (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       sel_we_i,
  input  logic [3:0] team_i,
  input  logic       lock_we_i,
  output logic [3:0] sel_o,
  output logic       lock_o
);
  logic [3:0] sel_q, sel_d;

  assign sel_d = sel_we_i ? team_i : sel_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) sel_q <= '0;
    else          sel_q <= sel_d;

  assign sel_o = sel_q;

`ifdef GPIO_OWNER_LOCK_EN
  logic lock_q, lock_d;

  assign lock_d = lock_q | lock_we_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) lock_q <= 1'b0;
    else          lock_q <= lock_d;

  assign lock_o = lock_q;
`else
  logic unused_lock_we;
  assign unused_lock_we = lock_we_i;
  assign lock_o         = 1'b0;
`endif
endmodule

module gpio_owner_switch_ctrl #(
  parameter int NUM_TEAMS    = 12,
  parameter int NUM_PINS     = 38,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [5:0]            req_pin_i,
  input  logic [3:0]            req_team_i,
  input  logic                  lock_set_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [4*NUM_PINS-1:0] pin_sel_o,
  output logic [NUM_PINS-1:0]   force_oeb_o
);
  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_GUARD, S_MAKE} state_e;

  localparam logic [6:0] NP7 = 7'(NUM_PINS);
  localparam logic [4:0] NT5 = 5'(NUM_TEAMS);
  // Counter runs GUARD_CYCLES-1 down to 0, one GUARD cycle per value.
  localparam logic [3:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? 4'(GUARD_CYCLES - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] pin_q, pin_d;
  logic [3:0] team_q, team_d;
  logic       err_q, err_d;
  logic       nop_q, nop_d;   // done pulse for requests that need no switch

  logic [NUM_PINS-1:0][3:0] sel;
  logic [NUM_PINS-1:0]      lock;
  logic [NUM_PINS-1:0]      sel_we, lock_we;
  logic [NUM_PINS-1:0]      pin_oh, req_oh;
  logic [3:0]               cur_owner;
  logic                     cur_lock;
  logic                     accept, pin_oob, team_oob, lock_req;

`ifdef GPIO_OWNER_LOCK_EN
  assign lock_req = lock_set_i;
`else
  logic unused_lock_set;
  assign unused_lock_set = lock_set_i;
  assign lock_req        = 1'b0;
`endif

  assign req_ready_o = (state_q == S_IDLE) && !wb_rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign pin_oob     = {1'b0, req_pin_i} >= NP7;
  assign team_oob    = {1'b0, req_team_i} > NT5;

  // One-hot decodes for the requested pin and the latched pin; the owner and
  // lock lookups only hit when the requested index is in range.
  always_comb begin
    pin_oh    = '0;
    req_oh    = '0;
    cur_owner = '0;
    cur_lock  = 1'b0;
    for (int p = 0; p < NUM_PINS; p++) begin
      pin_oh[p] = (pin_q == 6'(p));
      req_oh[p] = (req_pin_i == 6'(p));
      if (req_oh[p]) begin
        cur_owner = sel[p];
        cur_lock  = lock[p];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pin_q   <= '0;
      team_q  <= '0;
      err_q   <= 1'b0;
      nop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      team_q  <= team_d;
      err_q   <= err_d;
      nop_q   <= nop_d;
    end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    team_d  = team_q;
    err_d   = 1'b0;
    nop_d   = 1'b0;
    sel_we  = '0;
    lock_we = '0;
    case (state_q)
      S_IDLE:
        if (accept) begin
          pin_d  = req_pin_i;
          team_d = req_team_i;
          if (pin_oob || team_oob || cur_lock) begin
            err_d = 1'b1;
          end else if (lock_req) begin
            nop_d   = 1'b1;
            lock_we = req_oh;
          end else if (cur_owner == req_team_i) begin
            nop_d = 1'b1;
          end else begin
            state_d = S_BREAK;
          end
        end
      S_BREAK:
        if (GUARD_CYCLES == 0) begin
          state_d = S_MAKE;
          sel_we  = pin_oh;
        end else begin
          state_d = S_GUARD;
          cnt_d   = GUARD_LOAD;
        end
      S_GUARD:
        if (cnt_q == 4'd0) begin
          state_d = S_MAKE;
          sel_we  = pin_oh;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      S_MAKE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    gpio_owner_pin_cell u_cell (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .sel_we_i  (sel_we[p]),
      .team_i    (team_q),
      .lock_we_i (lock_we[p]),
      .sel_o     (sel[p]),
      .lock_o    (lock[p])
    );
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = nop_q || (state_q == S_MAKE);
  assign err_o       = err_q;
  assign pin_sel_o   = sel;
  assign force_oeb_o = busy_o ? pin_oh : '0;
endmodule

// File: tb/tb_gpio_owner_switch_ctrl.sv
module tb_gpio_owner_switch_ctrl;
  localparam int NP = 38;
  localparam int NT = 12;
  localparam int SW = 4 * NP;
`ifdef GPIO_OWNER_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // index 0: GUARD_CYCLES = 4, index 1: GUARD_CYCLES = 0
  logic          vld[2], lk[2];
  logic [5:0]    rpin[2];
  logic [3:0]    rteam[2];
  logic          rdy[2], busy[2], done[2], err[2];
  logic [SW-1:0] sel[2];
  logic [NP-1:0] foe[2];

  gpio_owner_switch_ctrl #(.NUM_TEAMS(NT), .NUM_PINS(NP), .GUARD_CYCLES(4)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
    .req_pin_i(rpin[0]), .req_team_i(rteam[0]), .lock_set_i(lk[0]), .busy_o(busy[0]),
    .done_o(done[0]), .err_o(err[0]), .pin_sel_o(sel[0]), .force_oeb_o(foe[0]));

  gpio_owner_switch_ctrl #(.NUM_TEAMS(NT), .NUM_PINS(NP), .GUARD_CYCLES(0)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
    .req_pin_i(rpin[1]), .req_team_i(rteam[1]), .lock_set_i(lk[1]), .busy_o(busy[1]),
    .done_o(done[1]), .err_o(err[1]), .pin_sel_o(sel[1]), .force_oeb_o(foe[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [SW-1:0] act, logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a switch is just "busy for G+2 cycles, new owner shown in the last one".
  int         left[2];
  logic       m_err[2], m_nop[2];
  logic [3:0] owner[2][64];
  logic       lockm[2][64];
  logic [5:0] spin[2];
  logic [3:0] steam[2];

  function automatic int gc(int i);
    return (i == 0) ? 4 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        left[i] <= 0; m_err[i] <= 1'b0; m_nop[i] <= 1'b0;
        spin[i] <= '0; steam[i] <= '0;
        for (int p = 0; p < 64; p++) begin
          owner[i][p] <= '0; lockm[i][p] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_err[i] <= 1'b0;
        m_nop[i] <= 1'b0;
        if (left[i] > 0) begin
          left[i] <= left[i] - 1;
          if (left[i] == 2) owner[i][spin[i]] <= steam[i];
        end else if (vld[i]) begin
          if (int'(rpin[i]) >= NP || int'(rteam[i]) > NT || lockm[i][rpin[i]]) m_err[i] <= 1'b1;
          else if (LOCK && lk[i]) begin lockm[i][rpin[i]] <= 1'b1; m_nop[i] <= 1'b1; end
          else if (owner[i][rpin[i]] == rteam[i]) m_nop[i] <= 1'b1;
          else begin left[i] <= gc(i) + 2; spin[i] <= rpin[i]; steam[i] <= rteam[i]; end
        end
      end
    end
  end

  task automatic cmp_model();
    for (int i = 0; i < 2; i++) begin
      logic [SW-1:0] es;
      logic [NP-1:0] ef;
      es = '0;
      ef = '0;
      for (int p = 0; p < NP; p++) es[4*p +: 4] = owner[i][p];
      if (left[i] > 0) ef[spin[i]] = 1'b1;
      chk($sformatf("dut%0d ready", i), rdy[i],  (left[i] == 0 && !rst));
      chk($sformatf("dut%0d busy", i),  busy[i], (left[i] > 0));
      chk($sformatf("dut%0d done", i),  done[i], (m_nop[i] || left[i] == 1));
      chk($sformatf("dut%0d err", i),   err[i],  m_err[i]);
      chk($sformatf("dut%0d sel", i),   sel[i],  es);
      chk($sformatf("dut%0d force", i), foe[i],  ef);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic req(int i, int pin, int team, logic lock);
    vld[i] = 1'b1; rpin[i] = 6'(pin); rteam[i] = 4'(team); lk[i] = lock;
    tick();
    vld[i] = 1'b0; lk[i] = 1'b0;
  endtask

  // Sample k is taken after edge k-1 (edge 0 = acceptance).
  task automatic observe(int i, int pin, int n, output int fc, output int dc, output int ec,
                         output int bc, output int rdy_at, output int dk, output logic [3:0] seld);
    fc = 0; dc = 0; ec = 0; bc = 0; rdy_at = -1; dk = -1; seld = '0;
    for (int k = 1; k <= n; k++) begin
      if (foe[i][pin]) fc++;
      if (busy[i]) bc++;
      if (err[i]) ec++;
      if (done[i]) begin
        dc++;
        if (dk < 0) begin dk = k; seld = sel[i][4*pin +: 4]; end
      end
      if (rdy[i] && rdy_at < 0) rdy_at = k;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fc, dc, ec, bc, ra, dk;
    logic [3:0] sd;
    logic [SW-1:0] snap;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; lk[i] = 1'b0; rpin[i] = '0; rteam[i] = '0;
    end
    #1 rst = 1'b1;
    #1;
    chk("reset ready", rdy[0], 0);
    chk("reset busy",  busy[0], 0);
    chk("reset sel",   sel[0], 0);
    chk("reset force", foe[0], 0);
    tick(); tick();
    rst = 1'b0;
    #1 chk("ready after reset", rdy[0], 1);
    tick();

    // pin 5 -> team 3, guard 4
    req(0, 5, 3, 1'b0);
    observe(0, 5, 10, fc, dc, ec, bc, ra, dk, sd);
    chk("s1 force cycles", fc, 6);
    chk("s1 done count",   dc, 1);
    chk("s1 make select",  sd, 3);
    chk("s1 ready again",  ra, 7);
    chk("s1 err count",    ec, 0);

    // out-of-range pin, then out-of-range team
    snap = sel[0];
    req(0, 38, 2, 1'b0);
    observe(0, 0, 4, fc, dc, ec, bc, ra, dk, sd);
    chk("s2a err count", ec, 1);
    chk("s2a done count", dc, 0);
    chk("s2a busy", bc, 0);
    chk("s2a sel", sel[0], snap);
    chk("s2a force", foe[0], 0);
    req(0, 0, 13, 1'b0);
    observe(0, 0, 4, fc, dc, ec, bc, ra, dk, sd);
    chk("s2b err count", ec, 1);
    chk("s2b done count", dc, 0);
    chk("s2b sel", sel[0], snap);
    chk("s2b force", foe[0], 0);

    // same-owner request
    req(0, 7, 3, 1'b0);
    observe(0, 7, 10, fc, dc, ec, bc, ra, dk, sd);
    chk("s3 setup owner", sel[0][31:28], 3);
    req(0, 7, 3, 1'b0);
    observe(0, 7, 4, fc, dc, ec, bc, ra, dk, sd);
    chk("s3 done next cycle", dk, 1);
    chk("s3 done count", dc, 1);
    chk("s3 force", fc, 0);
    chk("s3 busy", bc, 0);

    // guard 0 build
    req(1, 3, 5, 1'b0);
    observe(1, 3, 6, fc, dc, ec, bc, ra, dk, sd);
    req(1, 0, 1, 1'b0);
    observe(1, 0, 6, fc, dc, ec, bc, ra, dk, sd);
    chk("s6 force cycles", fc, 2);
    chk("s6 done count", dc, 1);
    chk("s6 ready again", ra, 3);
    chk("s6 make select", sd, 1);
    chk("s6 pin3 kept", sel[1][15:12], 5);
    snap = sel[1];
    snap[3:0] = '0;
    snap[15:12] = '0;
    chk("s6 others zero", snap, 0);

    // lock pin 2, then try to move it
    req(0, 2, 0, 1'b1);
    observe(0, 2, 4, fc, dc, ec, bc, ra, dk, sd);
    chk("s7 lock done", dc, 1);
    req(0, 2, 4, 1'b0);
    observe(0, 2, 10, fc, dc, ec, bc, ra, dk, sd);
`ifdef GPIO_OWNER_LOCK_EN
    chk("s7 locked err", ec, 1);
    chk("s7 locked force", fc, 0);
    chk("s7 locked owner", sel[0][11:8], 0);
`else
    chk("s7 unlocked err", ec, 0);
    chk("s7 unlocked force", fc, 6);
    chk("s7 unlocked owner", sel[0][11:8], 4);
`endif

    // reset during GUARD of pin 10 -> team 6
    req(0, 10, 6, 1'b0);
    tick(); tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("s5 ready in reset", rdy[0], 0);
    chk("s5 busy in reset",  busy[0], 0);
    chk("s5 done in reset",  done[0], 0);
    chk("s5 err in reset",   err[0], 0);
    chk("s5 sel in reset",   sel[0], 0);
    chk("s5 force in reset", foe[0], 0);
    @(negedge clk);
    cmp_model();
    tick();
    rst = 1'b0;
    #1 chk("s5 ready after reset", rdy[0], 1);
    req(0, 10, 6, 1'b0);
    observe(0, 10, 10, fc, dc, ec, bc, ra, dk, sd);
    chk("s5 retry force", fc, 6);
    chk("s5 retry done", dc, 1);
    chk("s5 retry select", sel[0][43:40], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_owner_switch_ctrl.md
GPIO_OWNER_SWITCH_CTRL -- requirements
Module: gpio_owner_switch_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_TEAMS, default 12, the highest valid owner index; owners are 0..NUM_TEAMS.
REQ-002 The block SHALL have parameter NUM_PINS, default 38, the number of GPIO pins managed.
REQ-003 The block SHALL have parameter GUARD_CYCLES, default 4, the number of break-before-make tristate cycles; legal range 0..15.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- wb_clk_i  in  1  sole clock; all state changes on its rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  reassignment request valid.
- req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high at a rising edge.
- req_pin_i  in  6  target pin index.
- req_team_i  in  4  new owner index.
- lock_set_i  in  1  with req_valid_i, a lock request for req_pin_i; only meaningful under REQ-020.
- busy_o  out  1  high whenever the FSM is not IDLE.
- done_o  out  1  one-cycle pulse when a reassignment completes.
- err_o  out  1  one-cycle pulse when a request is rejected.
- pin_sel_o  out  4*NUM_PINS  per-pin owner select; pin p occupies bits [4p+3:4p].
- force_oeb_o  out  NUM_PINS  per-pin override; a 1 forces the pin's output enable inactive (tristate) downstream.

Function
REQ-005 The FSM SHALL have states IDLE, BREAK, GUARD and MAKE, with req_ready_o = 1 only in IDLE.
REQ-006 On acceptance, the block SHALL latch req_pin_i and req_team_i into internal registers.
REQ-007 A request SHALL be rejected when req_pin_i >= NUM_PINS or req_team_i > NUM_TEAMS: err_o pulses the cycle after acceptance, the FSM stays in IDLE, and no output changes.
REQ-008 A valid request whose req_team_i equals the pin's current owner SHALL complete without switching: done_o pulses the cycle after acceptance, the FSM stays in IDLE, and force_oeb_o is untouched.
REQ-009 Every other accepted request SHALL proceed as IDLE -> BREAK (1 cycle) -> GUARD (GUARD_CYCLES cycles) -> MAKE (1 cycle) -> IDLE.
REQ-010 When GUARD_CYCLES = 0, BREAK SHALL go directly to MAKE.
REQ-011 force_oeb_o[pin] SHALL be 1 from the first BREAK cycle through the MAKE cycle inclusive, and SHALL be 0 from the first IDLE cycle onward.
REQ-012 The pin_sel_o field for the pin SHALL take the new owner at the rising edge that enters MAKE, so the new select is visible while the pin is still forced tristate.
REQ-013 done_o SHALL be high exactly during the MAKE cycle.
REQ-014 With acceptance at edge 0, the pin's tristate window SHALL be GUARD_CYCLES+2 cycles, and req_ready_o SHALL be high again GUARD_CYCLES+3 cycles after acceptance.
REQ-015 The GUARD counter SHALL be 4 bits, load GUARD_CYCLES-1 on entry, decrement each cycle, and exit at 0 with no wrap.
REQ-016 Changes to req_* inputs while busy_o = 1 SHALL have no effect.
REQ-017 Only the latched pin's select and force bits SHALL change during a switch; all other pins SHALL hold their values.

Reset
REQ-018 While wb_rst_i = 1, and immediately on its assertion regardless of clock, the block SHALL hold:
- FSM = IDLE, all pin_sel_o fields = 0, force_oeb_o = 0;
- busy_o = 0, done_o = 0, err_o = 0, req_ready_o = 0;
- guard counter and all locks cleared.
REQ-019 Reset asserted mid-switch SHALL abort the switch with no done_o pulse; the affected pin returns to owner 0 with force cleared, and req_ready_o = 1 on the first edge after deassertion.

Configuration
REQ-020 Macro GPIO_OWNER_LOCK_EN SHALL control pin locking:
- Defined: a valid accepted request with lock_set_i = 1 sets a sticky per-pin lock bit and pulses done_o the next cycle with no owner change; any later request, ownership or lock, to a locked pin is rejected per REQ-007; locks clear only on reset.
- Undefined: lock_set_i is ignored, no lock storage is built, and every request is treated as an ownership request.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then pin 5 -> team 3 with GUARD_CYCLES = 4: force_oeb_o[5] high for 6 cycles; pin_sel_o[23:20] = 3 on MAKE entry; done_o pulses once; ready again 7 cycles after acceptance.
- Request pin 38 team 2, and separately pin 0 team 13: err_o pulses once each; pin_sel_o and force_oeb_o unchanged.
- Pin 7 already owner 3, request team 3: done_o the next cycle, force_oeb_o stays 0, busy_o stays 0.
- Assert reset during GUARD of pin 10 -> team 6: all outputs 0 at once, no done_o; a fresh request for pin 10 works after deassertion.
- GUARD_CYCLES = 0 build, pin 0 -> team 1: 2-cycle tristate window; other pins' fields unchanged.
- GPIO_OWNER_LOCK_EN defined: lock pin 2, then request pin 2 -> team 4: err_o pulses and the owner stays 0; same stimulus without the macro: switch completes.
